// File: rtl/vga_text_writer_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_text_writer_if
// Description : Character-in / glyph-write-out bundle between the CPU side,
//               the text writer and the vga_controller block RAM port.
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_text_writer_if;
  logic        in_valid;
  logic [7:0]  in_char;
  logic        in_ready;
  logic        write_op;
  logic [31:0] bus_addr;
  logic [31:0] bus_data;
  logic [6:0]  cursor_col;
  logic [5:0]  cursor_row;
  logic        busy;

  // CPU / stimulus side
  modport master (
    output in_valid, in_char,
    input  in_ready, write_op, bus_addr, bus_data, cursor_col, cursor_row, busy
  );

  // Text writer side
  modport slave (
    input  in_valid, in_char,
    output in_ready, write_op, bus_addr, bus_data, cursor_col, cursor_row, busy
  );
endinterface
`default_nettype wire

// File: rtl/vga_text_writer.sv
`default_nettype none
// ============================================================================
// Module      : vga_text_writer
// Description : Turns a putchar byte stream into block-addressed glyph writes
//               for vga_controller. Tracks a text cursor, handles CR/LF/BS/FF
//               and line wrap, clears the screen after reset and clears each
//               new row before it is used.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_text_writer #(
  parameter int         COLS  = 100,
  parameter int         ROWS  = 37,
  parameter logic [7:0] SPACE = 8'h20
) (
  input  wire logic         clk_50M,
  input  wire logic         rst,
  vga_text_writer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CLEAR_ALL = 2'd1,
    CLEAR_ROW = 2'd2
  } state_t;

  localparam logic [12:0] TOTAL    = 13'(ROWS * COLS);
  localparam logic [12:0] COLS_W   = 13'(COLS);
  localparam logic [6:0]  LAST_COL = 7'(COLS - 1);
  localparam logic [5:0]  LAST_ROW = 6'(ROWS - 1);

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  state_t      state_q;
  logic [12:0] clr_addr_q;   // next address the running clear will write
  logic [12:0] clr_end_q;    // one past the last address of the running clear
  logic [6:0]  col_q;
  logic [5:0]  row_q;
  logic        wr_q;
  logic [12:0] addr_q;
  logic [7:0]  data_q;

  logic [5:0]  w_next_row;
  logic [12:0] w_row_base;
  logic [12:0] w_next_base;
  logic [12:0] w_cur_addr;
  logic [12:0] w_bs_addr;
  logic        w_printable;

  // Address arithmetic for the current cursor and the row a newline lands on
  always_comb begin
    w_next_row  = (row_q == LAST_ROW) ? 6'd0 : row_q + 6'd1;
    w_row_base  = 13'(row_q) * COLS_W;
    w_next_base = 13'(w_next_row) * COLS_W;
    w_cur_addr  = w_row_base + 13'(col_q);
    w_bs_addr   = w_row_base + 13'(col_q - 7'd1);
    w_printable = (bus.in_char >= 8'h20) && (bus.in_char <= 8'h7E);
  end

  // Cursor / clear FSM with registered glyph-write outputs
  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      state_q    <= CLEAR_ALL;
      clr_addr_q <= 13'd0;
      clr_end_q  <= TOTAL;
      col_q      <= 7'd0;
      row_q      <= 6'd0;
      wr_q       <= 1'b0;
      addr_q     <= 13'd0;
      data_q     <= 8'd0;
    end else begin
      wr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            if (w_printable) begin
              wr_q   <= 1'b1;
              addr_q <= w_cur_addr;
              data_q <= bus.in_char;
              if (col_q < LAST_COL) begin
                col_q <= col_q + 7'd1;
              end else begin
                // Wrap: glyph goes out next cycle, row clear right behind it
                col_q      <= 7'd0;
                row_q      <= w_next_row;
                clr_addr_q <= w_next_base;
                clr_end_q  <= w_next_base + COLS_W;
                state_q    <= CLEAR_ROW;
              end
            end else if (bus.in_char == CH_LF) begin
              col_q      <= 7'd0;
              row_q      <= w_next_row;
              clr_addr_q <= w_next_base;
              clr_end_q  <= w_next_base + COLS_W;
              state_q    <= CLEAR_ROW;
            end else if (bus.in_char == CH_CR) begin
              col_q <= 7'd0;
            end else if (bus.in_char == CH_BS) begin
              if (col_q != 7'd0) begin
                col_q  <= col_q - 7'd1;
                wr_q   <= 1'b1;
                addr_q <= w_bs_addr;
                data_q <= SPACE;
              end
            end else if (bus.in_char == CH_FF) begin
              col_q      <= 7'd0;
              row_q      <= 6'd0;
              clr_addr_q <= 13'd0;
              clr_end_q  <= TOTAL;
              state_q    <= CLEAR_ALL;
            end
          end
        end
        CLEAR_ALL, CLEAR_ROW: begin
          if (clr_addr_q == clr_end_q) begin
            state_q <= IDLE;
          end else begin
            wr_q       <= 1'b1;
            addr_q     <= clr_addr_q;
            data_q     <= SPACE;
            clr_addr_q <= clr_addr_q + 13'd1;
          end
        end
        default: state_q <= CLEAR_ALL;
      endcase
    end
  end

  assign bus.write_op   = wr_q;
  assign bus.bus_addr   = {19'd0, addr_q};
  assign bus.bus_data   = {24'd0, data_q};
  assign bus.cursor_col = col_q;
  assign bus.cursor_row = row_q;
  assign bus.in_ready   = (state_q == IDLE);
  assign bus.busy       = (state_q != IDLE);

endmodule
`default_nettype wire
